// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-stage types: physical register ids, optional-register struct,
// free-list pointer type and pointer helpers used by phys_reg_free_list.
package mips_core;

  localparam int NUM_PHYS_REGS  = 64;
  localparam int FREE_LIST_SIZE = NUM_PHYS_REGS - 32;
  localparam int PHYS_REG_W     = $clog2(NUM_PHYS_REGS);
  localparam int FL_IDX_W       = $clog2(FREE_LIST_SIZE);
  localparam int FREE_COUNT_W   = $clog2(FREE_LIST_SIZE + 1);

  typedef logic [PHYS_REG_W-1:0]   PhysReg;
  typedef logic [FREE_COUNT_W-1:0] FreeCount;

  typedef struct packed {
    logic   valid;
    PhysReg preg;
  } opt_PhysReg;

  // Circular-buffer pointer with an extra wrap bit to tell full from empty.
  typedef struct packed {
    logic                wrap;
    logic [FL_IDX_W-1:0] idx;
  } FlPtr;

  function automatic FlPtr fl_ptr_inc(FlPtr p);
    FlPtr r;
    r = p;
    if (p.idx == FL_IDX_W'(FREE_LIST_SIZE - 1)) begin
      r.idx  = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.idx = p.idx + FL_IDX_W'(1);
    end
    return r;
  endfunction

  function automatic FreeCount fl_distance(FlPtr from, FlPtr to);
    int d;
    if (from.wrap == to.wrap) d = int'(to.idx) - int'(from.idx);
    else                      d = FREE_LIST_SIZE + int'(to.idx) - int'(from.idx);
    return FreeCount'(d);
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Hazard-control bundle; the free list only consumes the flush request.
interface hazard_control_ifc;
  logic flush;

  modport in  (input  flush);
  modport out (output flush);
endinterface

// File: rtl/phys_reg_free_list.sv
// Physical-register free list: speculative head, commit head and tail over a
// circular buffer. Define FREE_LIST_CHECK_EN to add the free-bitmap checker.
module phys_reg_free_list
  import mips_core::*;
(
  input  logic              clk,
  input  logic              rst_n,
  hazard_control_ifc.in     i_hc,
  input  logic              i_alloc_req,
  output opt_PhysReg        o_alloc,
  input  opt_PhysReg        i_free,
  output logic              o_empty,
  output FreeCount          o_free_count,
  output logic              o_error
);

  PhysReg   entries [FREE_LIST_SIZE];
  FlPtr     head_reg, commit_head_reg, tail_reg;
  FlPtr     flush_head;
  FreeCount count;
  logic     grant, overflow, do_free;

  assign count         = fl_distance(head_reg, tail_reg);
  assign o_empty       = (count == '0);
  assign o_free_count  = count;
  assign o_alloc.valid = !o_empty;
  assign o_alloc.preg  = entries[head_reg.idx];

  assign grant    = i_alloc_req && !o_empty && !i_hc.flush;
  assign overflow = i_free.valid && (count == FreeCount'(FREE_LIST_SIZE));
  assign do_free  = i_free.valid && !overflow;

  // A free retiring in the flush cycle has already consumed its allocation.
  assign flush_head = i_free.valid ? fl_ptr_inc(commit_head_reg) : commit_head_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg        <= '0;
      commit_head_reg <= '0;
      tail_reg        <= '{wrap: 1'b1, idx: '0};
    end else begin
      if (i_hc.flush)  head_reg <= flush_head;
      else if (grant)  head_reg <= fl_ptr_inc(head_reg);
      if (i_free.valid) commit_head_reg <= fl_ptr_inc(commit_head_reg);
      if (do_free)      tail_reg <= fl_ptr_inc(tail_reg);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FREE_LIST_SIZE; i++) begin
      if (!rst_n)
        entries[i] <= PhysReg'(32 + i);
      else if (do_free && (tail_reg.idx == FL_IDX_W'(i)))
        entries[i] <= i_free.preg;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PHYS_REGS-1:0] free_map_reg, free_map_next;
  logic                     error_reg, error_next;
  FreeCount                 spec_count;

  assign spec_count = fl_distance(flush_head, head_reg);

  always_comb begin
    free_map_next = free_map_reg;
    error_next    = error_reg;
    if (grant) begin
      if (!free_map_reg[o_alloc.preg]) error_next = 1'b1;
      free_map_next[o_alloc.preg] = 1'b0;
    end
    if (i_free.valid) begin
      if (overflow || free_map_reg[i_free.preg]) error_next = 1'b1;
      if (!overflow) free_map_next[i_free.preg] = 1'b1;
    end
    // Speculative allocations discarded by a flush return to the free set.
    if (i_hc.flush) begin
      for (int i = 0; i < FREE_LIST_SIZE; i++) begin
        int off;
        off = (i - int'(flush_head.idx) + FREE_LIST_SIZE) % FREE_LIST_SIZE;
        if (off < int'(spec_count)) free_map_next[entries[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) free_map_reg[i] <= (i >= 32);
      error_reg <= 1'b0;
    end else begin
      free_map_reg <= free_map_next;
      error_reg    <= error_next;
    end
  end

  assign o_error = error_reg;
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed and constrained-random checks of phys_reg_free_list, with or
// without FREE_LIST_CHECK_EN.
module tb_phys_reg_free_list;
  import mips_core::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_req;
  opt_PhysReg alloc;
  opt_PhysReg free_in;
  logic       empty;
  FreeCount   free_count;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FREE_LIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  hazard_control_ifc hc ();

  phys_reg_free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_hc         (hc),
    .i_alloc_req  (alloc_req),
    .o_alloc      (alloc),
    .i_free       (free_in),
    .o_empty      (empty),
    .o_free_count (free_count),
    .o_error      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 1'b0;
    hc.flush  = 1'b0;
    free_in   = '0;
  endtask

  // Reset is held with every other input active to exercise its priority.
  task automatic do_reset();
    rst_n     = 1'b0;
    alloc_req = 1'b1;
    hc.flush  = 1'b1;
    free_in   = '{valid: 1'b1, preg: PhysReg'(3)};
    tick();
    tick();
    idle();
    rst_n = 1'b1;
  endtask

  task automatic grant_one(input string tag, input int exp_reg);
    check(tag, alloc.preg, exp_reg);
    alloc_req = 1'b1;
    tick();
    idle();
  endtask

  task automatic free_one(input int r);
    free_in = '{valid: 1'b1, preg: PhysReg'(r)};
    tick();
    idle();
  endtask

  int q[$];
  int pool[$];
  bit tb_free [NUM_PHYS_REGS];

  initial begin
    idle();
    rst_n = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", alloc.valid, 1);
    check("rst_reg", alloc.preg, 32);
    check("rst_empty", empty, 0);
    check("rst_count", free_count, FREE_LIST_SIZE);
    check("rst_error", err, 0);

    // Drain: 32 grants in order, then empty
    for (int i = 0; i < 32; i++) grant_one("drain_reg", 32 + i);
    check("drain_empty", empty, 1);
    check("drain_count", free_count, 0);
    check("drain_valid", alloc.valid, 0);

    // Empty with request and same-cycle free: no bypass
    alloc_req = 1'b1;
    free_in   = '{valid: 1'b1, preg: PhysReg'(40)};
    check("nobyp_valid", alloc.valid, 0);
    tick();
    idle();
    check("nobyp_valid_next", alloc.valid, 1);
    check("nobyp_reg_next", alloc.preg, 40);
    check("nobyp_count", free_count, 1);
    check("nobyp_error", err, 0);

    // 5 grants, 2 frees, flush back to commit head
    do_reset();
    for (int i = 0; i < 5; i++) grant_one("spec_reg", 32 + i);
    free_one(3);
    free_one(7);
    check("pre_flush_count", free_count, 29);
    hc.flush = 1'b1;
    tick();
    idle();
    check("flush_count", free_count, 32);
    grant_one("flush_reg0", 34);
    grant_one("flush_reg1", 35);
    check("flush_error", err, 0);

    // Flush coincident with a free: head lands past the retiring allocation
    hc.flush = 1'b1;
    free_in  = '{valid: 1'b1, preg: PhysReg'(9)};
    tick();
    idle();
    check("flfree_count", free_count, 32);
    for (int i = 0; i < 29; i++) grant_one("flfree_walk", 35 + i);
    grant_one("flfree_wrap0", 3);
    grant_one("flfree_wrap1", 7);
    check("flfree_entry9", alloc.preg, 9);
    check("flfree_count_end", free_count, 1);
    check("flfree_error", err, 0);

    // Overflow: free into a full list is dropped
    do_reset();
    free_one(5);
    check("ovf_count", free_count, 32);
    check("ovf_reg", alloc.preg, 32);
    check("ovf_error", err, CHK);

    // Random grant/free with wrap, checked against a FIFO and a bitmap
    do_reset();
    q.delete();
    pool.delete();
    for (int r = 0; r < NUM_PHYS_REGS; r++) begin
      tb_free[r] = (r >= 32);
      if (r >= 32) q.push_back(r);
      else         pool.push_back(r);
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      bit req;
      bit fr;
      check("rnd_count", free_count, q.size());
      req = 1'($urandom_range(0, 1));
      fr  = 1'($urandom_range(0, 1)) && (q.size() < 32) && (pool.size() > 0);
      alloc_req = req;
      if (req && q.size() > 0) begin
        int g;
        g = q.pop_front();
        check("rnd_reg", alloc.preg, g);
        check("rnd_once", tb_free[alloc.preg], 1);
        tb_free[g] = 1'b0;
        if (fr) begin
          int idx;
          int r;
          idx = $urandom_range(0, pool.size() - 1);
          r   = pool[idx];
          pool.delete(idx);
          free_in = '{valid: 1'b1, preg: PhysReg'(r)};
          tb_free[r] = 1'b1;
          q.push_back(r);
        end
        pool.push_back(g);
      end else if (fr) begin
        int idx;
        int r;
        idx = $urandom_range(0, pool.size() - 1);
        r   = pool[idx];
        pool.delete(idx);
        free_in = '{valid: 1'b1, preg: PhysReg'(r)};
        tb_free[r] = 1'b1;
        q.push_back(r);
      end
      tick();
      idle();
    end
    check("rnd_count_end", free_count, q.size());
    check("rnd_error", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
